// File: rtl/tmds_pkg.sv
// Shared TMDS definitions used by the encoder and the matching decoder.
//   CNT_W_DEFAULT - default width of the signed running-disparity counter
//   CTRL_TOKEN0-3 - 10-bit control-period symbols, indexed by {c1,c0}
//   popcount8     - number of ones in a byte
package tmds_pkg;

    localparam int CNT_W_DEFAULT = 8;

    localparam logic [9:0] CTRL_TOKEN0 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN1 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN2 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN3 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_qm.sv
// TMDS stage-1 transition minimiser (purely combinational).
//   d   in  8  pixel byte
//   q_m out 9  transition-minimised word; q_m[8]=1 marks XOR mode, 0 marks XNOR mode
module tmds_qm
    import tmds_pkg::*;
(
    input  logic [7:0] d,
    output logic [8:0] q_m
);

    logic [3:0] n1d;
    logic       use_xnor;
    logic [7:0] chain;

    assign n1d      = popcount8(d);
    // XNOR chaining is chosen for bytes with many ones, tie broken by d[0],
    // so the encoded word carries fewer transitions.
    assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);

    // NOTE: every variable written in a combinational block is given a value
    // on every path (here: before the loop) so no latch is inferred.
    always_comb begin
        chain    = '0;
        chain[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            chain[i] = use_xnor ? ~(chain[i-1] ^ d[i]) : (chain[i-1] ^ d[i]);
        end
    end

    assign q_m = {~use_xnor, chain};

endmodule

// File: rtl/tmds_encode.sv
// TMDS 8b/10b encoder for one DVI channel, two-stage pipeline.
//   clk   in  1      pixel clock, rising edge
//   rst   in  1      synchronous active-high reset (overrides en)
//   en    in  1      pipeline advance; 0 holds every register
//   d     in  8      pixel data (used when de=1)
//   c0    in  1      control bit 0 (used when de=0)
//   c1    in  1      control bit 1 (used when de=0)
//   de    in  1      1 = video data, 0 = control period
//   q_out out 10     encoded symbol, q_out[0] sent first
//   cnt   out CNT_W  signed running disparity since the last control token
module tmds_encode
    import tmds_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [7:0]              d,
    input  logic                    c0,
    input  logic                    c1,
    input  logic                    de,
    output logic [9:0]              q_out,
    output logic signed [CNT_W-1:0] cnt
);

    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);
    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);

    // Stage-1 pipeline registers
    logic       de_s1;
    logic [1:0] c_s1;
    logic [8:0] qm_s1;
    logic [8:0] qm_comb;

    tmds_qm u_qm (
        .d   (d),
        .q_m (qm_comb)
    );

    // Stage-2 decision
    logic [3:0]              n1q;
    logic signed [CNT_W-1:0] ones_s;
    logic signed [CNT_W-1:0] diff;      // n1q - n0q of q_m[7:0]
    logic                    cnt_pos;
    logic                    cnt_neg;
    logic [9:0]              q_next;
    logic signed [CNT_W-1:0] cnt_next;

    assign n1q     = popcount8(qm_s1[7:0]);
    assign ones_s  = $signed({{(CNT_W-4){1'b0}}, n1q});
    assign diff    = (ones_s <<< 1) - EIGHT;
    assign cnt_neg = cnt[CNT_W-1];
    assign cnt_pos = !cnt[CNT_W-1] && (cnt != '0);

    always_comb begin
        q_next   = CTRL_TOKEN0;
        cnt_next = '0;
        if (!de_s1) begin
            // A control token resets the running disparity.
            unique case (c_s1)
                2'b00: q_next = CTRL_TOKEN0;
                2'b01: q_next = CTRL_TOKEN1;
                2'b10: q_next = CTRL_TOKEN2;
                2'b11: q_next = CTRL_TOKEN3;
            endcase
            cnt_next = '0;
        end else if ((cnt == '0) || (diff == '0)) begin
            // No bias to correct: invert only in XNOR mode, so bit 9 always
            // differs from bit 8.
            q_next   = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
            cnt_next = qm_s1[8] ? (cnt + diff) : (cnt - diff);
        end else if ((cnt_pos && diff > 0) || (cnt_neg && diff < 0)) begin
            // Word would push disparity further the same way: send inverted.
            q_next   = {1'b1, qm_s1[8], ~qm_s1[7:0]};
            cnt_next = cnt + (qm_s1[8] ? TWO : '0) - diff;
        end else begin
            q_next   = {1'b0, qm_s1[8], qm_s1[7:0]};
            cnt_next = cnt + diff - (qm_s1[8] ? '0 : TWO);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_s1 <= 1'b0;
            c_s1  <= 2'b00;
            qm_s1 <= '0;
            q_out <= CTRL_TOKEN0;
            cnt   <= '0;
        end else if (en) begin
            de_s1 <= de;
            c_s1  <= {c1, c0};
            qm_s1 <= qm_comb;
            q_out <= q_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_tmds_encode.sv
module tb_tmds_encode;

    localparam int CNT_W = 8;

    logic                    clk;
    logic                    rst;
    logic                    en;
    logic [7:0]              d;
    logic                    c0;
    logic                    c1;
    logic                    de;
    logic [9:0]              q_out;
    logic signed [CNT_W-1:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    tmds_encode #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .d     (d),
        .c0    (c0),
        .c1    (c1),
        .de    (de),
        .q_out (q_out),
        .cnt   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] T2 = 10'b0101010100;
    localparam logic [9:0] T3 = 10'b1010101011;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Apply inputs, advance one edge, sample 1 time unit later.
    task automatic step(input logic r, input logic e, input logic dv,
                        input logic [1:0] c, input logic [7:0] dd);
        rst = r; en = e; de = dv; c1 = c[1]; c0 = c[0]; d = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [9:0] eq, input int ec);
        check({name, "_q"}, int'(q_out), int'(eq));
        check({name, "_cnt"}, int'(cnt), ec);
    endtask

    // ---------------- reference model helpers ----------------
    function automatic int ones_n(input logic [9:0] v, input int w);
        int n = 0;
        for (int i = 0; i < w; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [8:0] ref_qm(input logic [7:0] b);
        logic [8:0] r;
        int n;
        logic xn;
        n  = ones_n({2'b00, b}, 8);
        xn = (n > 4) || (n == 4 && b[0] == 1'b0);
        r[0] = b[0];
        for (int i = 1; i < 8; i++) r[i] = xn ? (r[i-1] ~^ b[i]) : (r[i-1] ^ b[i]);
        r[8] = !xn;
        return r;
    endfunction

    function automatic logic [9:0] ref_token(input logic [1:0] c);
        case (c)
            2'b00:   return T0;
            2'b01:   return T1;
            2'b10:   return T2;
            default: return T3;
        endcase
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] b;
        logic [7:0] o;
        b = s[9] ? ~s[7:0] : s[7:0];
        o[0] = b[0];
        for (int i = 1; i < 8; i++) o[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        return o;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       en;
        logic       de;
        logic [1:0] c;
        logic [7:0] d;
        logic [9:0] exp_q;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic dv, input logic [1:0] c,
                       input logic [7:0] dd, input logic [9:0] eq, input int ec);
        vec_t v;
        v.rst = r; v.en = e; v.de = dv; v.c = c; v.d = dd; v.exp_q = eq; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    // model state for the soak
    logic       m_de1;
    logic [1:0] m_c1;
    logic [7:0] m_d1;
    logic [9:0] m_q;
    int         m_cnt;
    logic       m_is_data;
    logic [7:0] m_d_out;

    initial begin
        rst = 1'b1; en = 1'b1; de = 1'b0; c0 = 1'b0; c1 = 1'b0; d = '0;

        // Each row: inputs applied before the edge, outputs expected after it
        // (outputs reflect the previous row's inputs).
        add(1, 1, 0, 2'b00, 8'hA5, T0, 0);            // reset
        add(1, 0, 1, 2'b11, 8'h3C, T0, 0);            // reset overrides en=0
        add(0, 1, 0, 2'b00, 8'h00, T0, 0);            // stage-1 reset token
        add(0, 1, 0, 2'b01, 8'h00, T0, 0);
        add(0, 1, 0, 2'b10, 8'h00, T1, 0);
        add(0, 1, 0, 2'b11, 8'h00, T2, 0);
        add(0, 1, 1, 2'b00, 8'h00, T3, 0);
        add(0, 1, 1, 2'b00, 8'h00, 10'b0100000000, -8);
        add(0, 1, 1, 2'b00, 8'h00, 10'b1111111111, 2);
        add(0, 1, 0, 2'b00, 8'h00, 10'b0100000000, -6);
        add(0, 1, 1, 2'b00, 8'hFF, T0, 0);            // token clears cnt
        add(0, 1, 0, 2'b00, 8'h00, 10'b1000000000, -8);
        add(0, 1, 1, 2'b00, 8'h55, T0, 0);
        add(0, 1, 0, 2'b00, 8'h00, 10'b0100110011, 0); // balanced word
        add(0, 1, 0, 2'b00, 8'h00, T0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].de, vecs[i].c, vecs[i].d);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt);
        end

        // Stall with inputs changing: outputs hold, FF is not lost.
        step(0, 1, 1, 2'b00, 8'h00); expect_out("stall_pre", T0, 0);
        step(0, 1, 1, 2'b00, 8'hFF); expect_out("stall_a", 10'b0100000000, -8);
        step(0, 0, 0, 2'b11, 8'h12); expect_out("stall_h0", 10'b0100000000, -8);
        step(0, 0, 1, 2'b01, 8'h00); expect_out("stall_h1", 10'b0100000000, -8);
        step(0, 0, 0, 2'b10, 8'hF0); expect_out("stall_h2", 10'b0100000000, -8);
        step(0, 1, 1, 2'b00, 8'h00); expect_out("stall_b", 10'b0011111111, -2);
        step(0, 1, 0, 2'b00, 8'h00); expect_out("stall_c", 10'b1111111111, 8);
        step(0, 1, 0, 2'b00, 8'h00); expect_out("stall_d", T0, 0);

        // Reset mid-stream discards the in-flight FF.
        step(0, 1, 1, 2'b00, 8'h00); expect_out("mrst_a", T0, 0);
        step(0, 1, 1, 2'b00, 8'hFF); expect_out("mrst_b", 10'b0100000000, -8);
        step(1, 1, 1, 2'b00, 8'h00); expect_out("mrst_r", T0, 0);
        step(0, 1, 1, 2'b00, 8'h00); expect_out("mrst_c", T0, 0);
        step(0, 1, 0, 2'b00, 8'h00); expect_out("mrst_d", 10'b0100000000, -8);

        // Random soak against the reference model.
        for (int it = 0; it < 10000; it++) begin
            logic       r;
            logic       e;
            logic       dv;
            logic [1:0] c;
            logic [7:0] dd;
            r  = (it == 0) || ($urandom_range(0, 299) == 0);
            e  = ($urandom_range(0, 9) < 8);
            dv = ($urandom_range(0, 9) < 7);
            c  = 2'($urandom_range(0, 3));
            dd = 8'($urandom_range(0, 255));
            rst = r; en = e; de = dv; c1 = c[1]; c0 = c[0]; d = dd;
            @(posedge clk);
            if (r) begin
                m_de1 = 1'b0; m_c1 = 2'b00; m_d1 = '0;
                m_q = T0; m_cnt = 0; m_is_data = 1'b0; m_d_out = '0;
            end else if (e) begin
                if (!m_de1) begin
                    m_q = ref_token(m_c1); m_cnt = 0; m_is_data = 1'b0;
                end else begin
                    logic [8:0] qm;
                    int n1;
                    logic inv;
                    qm = ref_qm(m_d1);
                    n1 = ones_n({2'b00, qm[7:0]}, 8);
                    if (m_cnt == 0 || n1 == 4)                           inv = !qm[8];
                    else if ((m_cnt > 0 && n1 > 4) || (m_cnt < 0 && n1 < 4)) inv = 1'b1;
                    else                                                 inv = 1'b0;
                    m_q = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
                    m_cnt = m_cnt + 2 * ones_n(m_q, 10) - 10;
                    m_is_data = 1'b1; m_d_out = m_d1;
                end
                m_de1 = dv; m_c1 = c; m_d1 = dd;
            end
            #1;
            check("soak_q", int'(q_out), int'(m_q));
            check("soak_cnt", int'(cnt), m_cnt);
            if (m_is_data) check("soak_decode", int'(decode(q_out)), int'(m_d_out));
            check("soak_bound", int'(int'(cnt) <= 10 && int'(cnt) >= -10), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
